// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates IF / LSB requests onto an 8-bit RAM/IO bus.
// Optional feature: define MEM_CTRL_IO_STALL_EN to hold IO-space writes while io_buffer_full is set.
module mem_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int IF_BYTES = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_data,
    input  logic              lsb_req_valid,
    input  logic              lsb_req_we,
    input  logic [1:0]        lsb_req_size,
    input  logic [ADDR_W-1:0] lsb_req_addr,
    input  logic [31:0]       lsb_req_wdata,
    output logic              lsb_resp_valid,
    output logic [31:0]       lsb_resp_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic              port_lsb_q, port_lsb_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic [7:0]        dout_q, dout_d;
    logic              wr_q, wr_d;
    logic              if_v_q, if_v_d, lsb_v_q, lsb_v_d;
    logic [31:0]       if_data_q, if_data_d, lsb_data_q, lsb_data_d;
    logic [2:0]        lsb_nbytes;
    logic [1:0]        lane;
    logic              io_stall;

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_stall = (state_q == WRITE) && (a_q[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign io_stall = 1'b0;
`endif

    assign lsb_nbytes = (lsb_req_size == 2'd0) ? 3'd1 : (lsb_req_size == 2'd1) ? 3'd2 : 3'd4;
    // Byte captured in read cycle cnt belongs to the address issued one cycle earlier.
    assign lane = cnt_q[1:0] - 2'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nbytes_d   = nbytes_q;
        port_lsb_d = port_lsb_q;
        a_d        = a_q;
        wbuf_d     = wbuf_q;
        rbuf_d     = rbuf_q;
        dout_d     = dout_q;
        wr_d       = wr_q;
        if_v_d     = if_v_q;
        lsb_v_d    = lsb_v_q;
        if_data_d  = if_data_q;
        lsb_data_d = lsb_data_q;
        if (rdy_in) begin
            if_v_d  = 1'b0;
            lsb_v_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!flush_in) begin
                        if (lsb_req_valid && !lsb_v_q) begin
                            port_lsb_d = 1'b1;
                            a_d        = lsb_req_addr;
                            nbytes_d   = lsb_nbytes;
                            cnt_d      = 3'd0;
                            rbuf_d     = 32'h0;
                            if (lsb_req_we) begin
                                state_d = WRITE;
                                wr_d    = 1'b1;
                                dout_d  = lsb_req_wdata[7:0];
                                wbuf_d  = {8'h00, lsb_req_wdata[31:8]};
                            end else begin
                                state_d = READ;
                            end
                        end else if (if_req_valid && !if_v_q) begin
                            port_lsb_d = 1'b0;
                            a_d        = if_req_addr;
                            nbytes_d   = 3'(IF_BYTES);
                            cnt_d      = 3'd0;
                            rbuf_d     = 32'h0;
                            state_d    = READ;
                        end
                    end
                end
                READ: begin
                    if (flush_in) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        if (cnt_q != 3'd0) rbuf_d[{lane, 3'b000} +: 8] = mem_din;
                        if (cnt_q == nbytes_q) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            if (port_lsb_q) begin
                                lsb_v_d    = 1'b1;
                                lsb_data_d = rbuf_d;
                            end else begin
                                if_v_d    = 1'b1;
                                if_data_d = rbuf_d;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q < nbytes_q - 3'd1) a_d = a_q + ADDR_W'(1);
                        end
                    end
                end
                WRITE: begin
                    // Stores are already committed, so flush does not cancel them.
                    if (!io_stall) begin
                        if (cnt_q == nbytes_q - 3'd1) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            wr_d    = 1'b0;
                            lsb_v_d = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + 3'd1;
                            a_d    = a_q + ADDR_W'(1);
                            dout_d = wbuf_q[7:0];
                            wbuf_d = {8'h00, wbuf_q[31:8]};
                            wr_d   = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            nbytes_q   <= 3'd0;
            port_lsb_q <= 1'b0;
            a_q        <= '0;
            wbuf_q     <= 32'h0;
            rbuf_q     <= 32'h0;
            dout_q     <= 8'h0;
            wr_q       <= 1'b0;
            if_v_q     <= 1'b0;
            lsb_v_q    <= 1'b0;
            if_data_q  <= 32'h0;
            lsb_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nbytes_q   <= nbytes_d;
            port_lsb_q <= port_lsb_d;
            a_q        <= a_d;
            wbuf_q     <= wbuf_d;
            rbuf_q     <= rbuf_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_v_q     <= if_v_d;
            lsb_v_q    <= lsb_v_d;
            if_data_q  <= if_data_d;
            lsb_data_q <= lsb_data_d;
        end
    end

    assign mem_a          = a_q;
    assign mem_dout       = dout_q;
    assign mem_wr         = wr_q & rdy_in & ~io_stall;
    assign if_resp_valid  = if_v_q;
    assign if_resp_data   = if_data_q;
    assign lsb_resp_valid = lsb_v_q;
    assign lsb_resp_rdata = lsb_data_q;

endmodule
